jpeg_out_port: RTL and testbench

- Memory-mapped output port on the core's data bus, alongside the data RAM.
- Captures 32-bit words that the JPEG encoder firmware stores to a fixed address and buffers them in a word FIFO.
- Serializes the buffered words MSB-byte-first onto a valid/ready byte stream consumed off-chip (UART/bitstream sink).
- Exposes a status/control register so firmware can poll occupancy and recover from overflow.

---
 rtl/jpeg_out_port_if.sv | 28 ++
 rtl/jpeg_out_port.sv | 169 ++++++++++++++++
 tb/tb_jpeg_out_port.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_out_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_out_port_if : core data-bus slot plus outgoing byte stream       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface jpeg_out_port_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wdata;
  logic             enw;
  logic [WIDTH-1:0] rdata;
  logic             hit;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;

  modport master (
    output address, wdata, enw, byte_ready,
    input  rdata, hit, byte_data, byte_valid
  );

  modport slave (
    input  address, wdata, enw, byte_ready,
    output rdata, hit, byte_data, byte_valid
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_out_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_out_port : store-mapped word FIFO serialised MSB-byte-first     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jpeg_out_port #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASEADDR = 32'h0000_0400
) (
  input wire logic        clock,
  input wire logic        reset,
  jpeg_out_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [15:0]     r_sent;
  logic [31:0]     r_shift;
  logic [1:0]      r_idx;

  logic            w_is_data;
  logic            w_is_stat;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_clr;
  logic            w_full;
  logic            w_empty;
  logic            w_xfer;
  logic            w_idle;
  logic [WIDTH-1:0] w_status;

  assign w_is_data  = (bus.address == BASEADDR);
  assign w_is_stat  = (bus.address == BASEADDR + 32'd4);
  assign w_push_req = bus.enw && w_is_data;
  assign w_flush    = bus.enw && w_is_stat && bus.wdata[1];
  assign w_clr      = bus.enw && w_is_stat && bus.wdata[0];

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_xfer  = (r_state == S_SEND) && bus.byte_ready;
  assign w_idle  = w_empty && (r_state == S_IDLE);

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push = w_push_req && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.byte_ready && (r_idx == 2'd3)) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) begin
      w_pop       = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_sent  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      if (w_clr) begin
        r_ovf <= 1'b0;
      end else if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (w_xfer) begin
        r_sent <= r_sent + 16'd1;
      end
      if (w_flush) begin
        r_idx <= '0;
      end else if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_idx   <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign bus.byte_valid = (r_state == S_SEND);

  always_comb begin
    bus.byte_data = 8'h00;
    if (r_state == S_SEND) begin
      case (r_idx)
        2'd0:    bus.byte_data = r_shift[31:24];
        2'd1:    bus.byte_data = r_shift[23:16];
        2'd2:    bus.byte_data = r_shift[15:8];
        default: bus.byte_data = r_shift[7:0];
      endcase
    end
  end

  assign w_status  = {r_sent, 8'(r_count), 5'b00000, r_ovf, w_idle, w_full};
  assign bus.hit   = w_is_data || w_is_stat;
  assign bus.rdata = w_is_stat ? w_status : '0;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_out_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jpeg_out_port : directed self-checking bench for jpeg_out_port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jpeg_out_port;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] STAT  = 32'h0000_0404;
  localparam logic [31:0] OTHER = 32'h0000_0408;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0]  got [64];
  int          got_n;
  int          first_c;
  int          last_c;
  logic [31:0] exp_w [16];
  logic [31:0] st;

  jpeg_out_port_if #(.WIDTH(32)) bus ();

  jpeg_out_port #(
    .WIDTH    (32),
    .DEPTH    (8),
    .BASEADDR (BASE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bsel(input logic [31:0] w, input int b);
    return w[31-8*b -: 8];
  endfunction

  function automatic logic [31:0] wd(input int i);
    return {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.address = a;
    bus.wdata   = d;
    bus.enw     = 1'b1;
    tick();
    bus.enw     = 1'b0;
    bus.address = OTHER;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.address = STAT;
    bus.enw     = 1'b0;
    #1;
    v = bus.rdata;
    bus.address = OTHER;
  endtask

  task automatic do_reset();
    bus.enw     = 1'b0;
    bus.address = OTHER;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
  endtask

  // Records accepted bytes; a byte held off by ready must not change.
  task automatic collect(input int n, input bit rnd, input int maxc);
    logic [7:0] pd;
    logic       pv;
    logic       pr;
    got_n   = 0;
    first_c = -1;
    last_c  = -1;
    pv      = 1'b0;
    pr      = 1'b1;
    pd      = 8'h00;
    for (int c = 0; c < maxc && got_n < n; c++) begin
      if (pv && !pr) begin
        check("hold_valid", 32'(bus.byte_valid), 32'd1);
        check("hold_data", 32'(bus.byte_data), 32'(pd));
      end
      if (rnd) bus.byte_ready = 1'($urandom_range(0, 1));
      if (bus.byte_valid && bus.byte_ready) begin
        got[got_n] = bus.byte_data;
        got_n++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      pv = bus.byte_valid;
      pr = bus.byte_ready;
      pd = bus.byte_data;
      tick();
    end
    check("collect_count", 32'(got_n), 32'(n));
    bus.byte_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int nwords);
    for (int j = 0; j < nwords * 4 && j < got_n; j++) begin
      check(tag, 32'(got[j]), 32'(bsel(exp_w[j/4], j % 4)));
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    bus.address    = OTHER;
    bus.wdata      = '0;
    bus.enw        = 1'b0;
    bus.byte_ready = 1'b1;
    reset          = 1'b1;
    tick();
    do_reset();

    // Reset state and address decode
    read_status(st);
    check("reset_status", st, 32'h0000_0002);
    check("reset_valid", 32'(bus.byte_valid), 32'd0);
    check("reset_data", 32'(bus.byte_data), 32'd0);
    bus.address = STAT; #1;
    check("hit_status", 32'(bus.hit), 32'd1);
    bus.address = BASE; #1;
    check("hit_data", 32'(bus.hit), 32'd1);
    check("rdata_data", bus.rdata, 32'd0);
    bus.address = OTHER; #1;
    check("hit_other", 32'(bus.hit), 32'd0);
    check("rdata_other", bus.rdata, 32'd0);

    // Single word: valid seen by the sink at edge k+2
    do_write(BASE, 32'hFFD8_FFE0);
    check("lat_valid_k1", 32'(bus.byte_valid), 32'd0);
    tick();
    check("lat_valid_k2", 32'(bus.byte_valid), 32'd1);
    check("lat_data_k2", 32'(bus.byte_data), 32'h0000_00FF);
    exp_w[0] = 32'hFFD8_FFE0;
    collect(4, 1'b0, 20);
    check_stream("single_byte", 1);
    check("single_gap", 32'(last_c - first_c), 32'd3);
    check("single_after_valid", 32'(bus.byte_valid), 32'd0);
    read_status(st);
    check("single_status", st, 32'h0004_0002);

    // Three words back-to-back, no bubbles
    do_reset();
    exp_w[0] = 32'h1122_3344;
    exp_w[1] = 32'h5566_7788;
    exp_w[2] = 32'h99AA_BBCC;
    fork
      begin
        do_write(BASE, exp_w[0]);
        do_write(BASE, exp_w[1]);
        do_write(BASE, exp_w[2]);
      end
      begin
        collect(12, 1'b0, 60);
      end
    join
    check_stream("b2b_byte", 3);
    check("b2b_gap", 32'(last_c - first_c), 32'd11);
    read_status(st);
    check("b2b_status", st, 32'h000C_0002);

    // Overflow: 10 words with the sink stalled
    do_reset();
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 10; i++) do_write(BASE, wd(i));
    read_status(st);
    check("ovf_status", st, 32'h0000_0805);
    check("ovf_valid", 32'(bus.byte_valid), 32'd1);
    check("ovf_head", 32'(bus.byte_data), 32'(bsel(wd(0), 0)));
    do_write(STAT, 32'h0000_0001);
    read_status(st);
    check("ovf_cleared", st, 32'h0000_0801);
    for (int i = 0; i < 9; i++) exp_w[i] = wd(i);
    bus.byte_ready = 1'b1;
    collect(36, 1'b0, 100);
    check_stream("ovf_byte", 9);
    check("ovf_after_valid", 32'(bus.byte_valid), 32'd0);
    read_status(st);
    check("ovf_final_status", st, 32'h0024_0002);

    // Random backpressure
    do_reset();
    exp_w[0] = 32'h0123_4567;
    do_write(BASE, exp_w[0]);
    collect(4, 1'b1, 200);
    check_stream("rnd_byte", 1);
    read_status(st);
    check("rnd_status", st, 32'h0004_0002);

    // Flush after byte 1 has been accepted
    do_reset();
    do_write(BASE, 32'hA1B2_C3D4);
    tick();
    check("fl_b0", 32'(bus.byte_data), 32'h0000_00A1);
    tick();
    check("fl_b1", 32'(bus.byte_data), 32'h0000_00B2);
    tick();
    check("fl_b2", 32'(bus.byte_data), 32'h0000_00C3);
    bus.byte_ready = 1'b0;
    do_write(STAT, 32'h0000_0002);
    check("fl_valid", 32'(bus.byte_valid), 32'd0);
    read_status(st);
    check("fl_status", st, 32'h0002_0002);
    bus.byte_ready = 1'b1;
    exp_w[0] = 32'h5566_7788;
    do_write(BASE, exp_w[0]);
    tick();
    check("fl_restart", 32'(bus.byte_data), 32'h0000_0055);
    collect(4, 1'b0, 20);
    check_stream("fl_byte", 1);

    // Reset mid-word
    do_write(BASE, 32'hA1B2_C3D4);
    tick();
    tick();
    check("rs_b1", 32'(bus.byte_data), 32'h0000_00B2);
    do_reset();
    check("rs_valid", 32'(bus.byte_valid), 32'd0);
    check("rs_data", 32'(bus.byte_data), 32'd0);
    read_status(st);
    check("rs_status", st, 32'h0000_0002);
    exp_w[0] = 32'hDEAD_BEEF;
    do_write(BASE, exp_w[0]);
    tick();
    check("rs_restart", 32'(bus.byte_data), 32'h0000_00DE);
    collect(4, 1'b0, 20);
    check_stream("rs_byte", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
